// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA operand geometry and ModExp state codes
package rsa_pkg;

   localparam int WIDTH      = 4096;
   localparam int DATA_WIDTH = 64;
   localparam int NWORDS     = WIDTH / DATA_WIDTH;

   // ModExp engine state codes as reported on exp_state
   localparam logic [4:0] INIT_STATE    = 5'd0;
   localparam logic [4:0] COMPLETE      = 5'd9;
   localparam logic [4:0] OUTPUT_RESULT = 5'd10;
   localparam logic [4:0] TERMINAL      = 5'd11;

endpackage

// File: rtl/modexp_loader.sv
// rtl/modexp_loader.sv - streams RSA operands into ModExp and gathers its result
module modexp_loader #(
   parameter int WIDTH      = rsa_pkg::WIDTH,
   parameter int DATA_WIDTH = rsa_pkg::DATA_WIDTH,
   parameter int TIMEOUT    = 1 << 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      message,
   input  logic [WIDTH-1:0]      exponent,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [WIDTH-1:0]      r_val,
   input  logic [WIDTH-1:0]      t_val,
   input  logic [DATA_WIDTH-1:0] nprime_in,
   output logic [DATA_WIDTH-1:0] m_buf,
   output logic [DATA_WIDTH-1:0] e_buf,
   output logic [DATA_WIDTH-1:0] n_buf,
   output logic [DATA_WIDTH-1:0] r_buf,
   output logic [DATA_WIDTH-1:0] t_buf,
   output logic [DATA_WIDTH-1:0] nprime0,
   output logic                  start_input,
   output logic                  start_compute,
   output logic                  get_result,
   input  logic [4:0]            exp_state,
   input  logic [DATA_WIDTH-1:0] res_out,
   output logic [WIDTH-1:0]      result,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);
   import rsa_pkg::COMPLETE;

   localparam int NWORDS = WIDTH / DATA_WIDTH;
   localparam int CW     = $clog2(NWORDS) + 1;
   localparam int WDW    = $clog2(TIMEOUT + 1);
   localparam int RW     = $clog2(WIDTH);

   localparam logic [CW-1:0]  CNT_LAST   = CW'(NWORDS - 1);
   localparam logic [CW-1:0]  CNT_STROBE = CW'(NWORDS);
   localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_CPL, READ, FINISH} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [WDW-1:0]        r_wdog;
   logic [WIDTH-1:0]      r_op_sh [5];
   logic [DATA_WIDTH-1:0] r_buf_q [5];
   logic [DATA_WIDTH-1:0] r_nprime;
   logic [WIDTH-1:0]      r_result;
   logic                  r_start_input;
   logic                  r_start_compute;
   logic                  r_get_result;
   logic                  r_done;
   logic                  r_timeout;

   logic [WIDTH-1:0]      w_ops [5];
   logic [RW-1:0]         w_rd_lsb;

   assign w_ops[0] = message;
   assign w_ops[1] = exponent;
   assign w_ops[2] = modulus;
   assign w_ops[3] = r_val;
   assign w_ops[4] = t_val;

   assign w_rd_lsb = RW'(r_cnt) * RW'(DATA_WIDTH);

   // Operand words leave from the bottom of right-shifting capture registers;
   // the watchdog starts counting on the start_compute cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_cnt           <= '0;
         r_wdog          <= '0;
         r_nprime        <= '0;
         r_result        <= '0;
         r_start_input   <= 1'b0;
         r_start_compute <= 1'b0;
         r_get_result    <= 1'b0;
         r_done          <= 1'b0;
         r_timeout       <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            r_op_sh[i] <= '0;
            r_buf_q[i] <= '0;
         end
      end else begin
         r_start_compute <= 1'b0;
         r_get_result    <= 1'b0;
         r_done          <= 1'b0;
         r_timeout       <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < 5; i++) begin
                     r_buf_q[i] <= w_ops[i][DATA_WIDTH-1:0];
                     r_op_sh[i] <= w_ops[i] >> DATA_WIDTH;
                  end
                  r_nprime      <= nprime_in;
                  r_start_input <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= SEND;
               end
            end
            SEND: begin
               if (r_cnt == CNT_LAST) begin
                  for (int i = 0; i < 5; i++) r_buf_q[i] <= '0;
                  r_start_input   <= 1'b0;
                  r_start_compute <= 1'b1;
                  r_get_result    <= 1'b1;
                  r_wdog          <= '0;
                  r_cnt           <= CNT_STROBE;
               end else if (r_cnt == CNT_STROBE) begin
                  r_wdog  <= r_wdog + 1'b1;
                  r_state <= WAIT_CPL;
               end else begin
                  for (int i = 0; i < 5; i++) begin
                     r_buf_q[i] <= r_op_sh[i][DATA_WIDTH-1:0];
                     r_op_sh[i] <= r_op_sh[i] >> DATA_WIDTH;
                  end
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_CPL: begin
               r_wdog <= r_wdog + 1'b1;
               if (exp_state == COMPLETE) begin
                  r_cnt   <= '0;
                  r_state <= READ;
               end else if (r_wdog >= WD_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            READ: begin
               r_result[w_rd_lsb +: DATA_WIDTH] <= res_out;
               if (r_cnt == CNT_LAST) begin
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            FINISH:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m_buf         = r_buf_q[0];
   assign e_buf         = r_buf_q[1];
   assign n_buf         = r_buf_q[2];
   assign r_buf         = r_buf_q[3];
   assign t_buf         = r_buf_q[4];
   assign nprime0       = r_nprime;
   assign start_input   = r_start_input;
   assign start_compute = r_start_compute;
   assign get_result    = r_get_result;
   assign result        = r_result;
   assign busy          = (r_state != IDLE);
   assign done          = r_done;
   assign timeout_err   = r_timeout;

endmodule

// File: tb/tb_modexp_loader.sv
// tb/tb_modexp_loader.sv - self-checking bench for modexp_loader
module tb_modexp_loader;

   localparam int WIDTH = 4096;
   localparam int DW    = 64;
   localparam int NW    = WIDTH / DW;
   localparam int TO    = 100;
   localparam int S     = NW + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] message, exponent, modulus, r_val, t_val;
   logic [DW-1:0]    nprime_in;
   logic [DW-1:0]    m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
   logic             start_input, start_compute, get_result;
   logic [4:0]       exp_state;
   logic [DW-1:0]    res_out;
   logic [WIDTH-1:0] result;
   logic             busy, done, timeout_err;

   modexp_loader #(.WIDTH(WIDTH), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .message(message), .exponent(exponent), .modulus(modulus),
      .r_val(r_val), .t_val(t_val), .nprime_in(nprime_in),
      .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
      .nprime0(nprime0), .start_input(start_input), .start_compute(start_compute),
      .get_result(get_result), .exp_state(exp_state), .res_out(res_out),
      .result(result), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mode;         // 0 nominal 8/13/77, 1 word-index pattern, 2 random
      int wait_cyc;     // WAIT_CPL cycles before COMPLETE; 0 = never completes
      int reset_at;     // cycle of a one-cycle reset pulse; 0 = none
      bit extra_start;  // extra start pulses while busy and on the done cycle
      bit exp_done;
      bit exp_timeout;
      int exp_latency;  // start cycle to done cycle
   } vec_t;

   vec_t          vecs [8];
   int            n_checks = 0;
   int            n_errors = 0;
   int            cur_t    = 0;
   logic [WIDTH-1:0] op [5];
   logic [DW-1:0] np;
   logic [DW-1:0] resw    [NW];
   logic [DW-1:0] exp_res [NW];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cur_t, act, exp);
      end
   endtask

   task automatic check_result(input string tag);
      for (int k = 0; k < NW; k++)
         chk($sformatf("%s result[%0d]", tag, k), result[k*DW +: DW], exp_res[k]);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int t_done, t_to, t_end, last_busy;
      bit alive, in_send;
      string tag;
      logic [DW-1:0] exp_buf [5];
      logic [DW-1:0] act_buf [5];
      tag = $sformatf("v%0d", idx);
      for (int i = 0; i < 5; i++)
         for (int b = 0; b < WIDTH / 32; b++) op[i][b*32 +: 32] = $urandom;
      np = {$urandom, $urandom};
      for (int k = 0; k < NW; k++) resw[k] = {$urandom, $urandom};
      if (v.mode == 0) begin
         op[0] = WIDTH'(8);
         op[1] = WIDTH'(13);
         op[2] = WIDTH'(77);
         for (int k = 0; k < NW; k++) resw[k] = '0;
         resw[0] = 64'd50;
      end else if (v.mode == 1) begin
         for (int k = 0; k < NW; k++) begin
            op[0][k*DW +: DW] = 64'(k);
            resw[k] = 64'(k);
         end
      end
      t_done    = v.exp_done ? v.exp_latency : -1;
      t_to      = v.exp_timeout ? S + TO : -1;
      last_busy = v.exp_done ? t_done : (v.exp_timeout ? t_to - 1 : v.reset_at);
      t_end     = last_busy + 3;

      @(negedge clk);
      cur_t     = 0;
      start     = 1'b1;
      message   = op[0];
      exponent  = op[1];
      modulus   = op[2];
      r_val     = op[3];
      t_val     = op[4];
      nprime_in = np;
      exp_state = 5'd0;
      res_out   = {$urandom, $urandom};

      for (int t = 1; t <= t_end; t++) begin
         @(negedge clk);
         cur_t = t;
         start = v.extra_start && (t == 30 || t == t_done);
         reset = (v.reset_at != 0) && (t == v.reset_at);
         if (t == 1) begin
            message   = ~op[0];
            exponent  = ~op[1];
            modulus   = ~op[2];
            r_val     = ~op[3];
            t_val     = ~op[4];
            nprime_in = ~np;
         end
         exp_state = (v.wait_cyc > 0 && t == S + v.wait_cyc) ? 5'd9 : 5'(t % 9);
         if (v.wait_cyc > 0 && t >= S + v.wait_cyc + 1 && t <= S + v.wait_cyc + NW)
            res_out = resw[t - S - v.wait_cyc - 1];
         else
            res_out = {$urandom, $urandom};

         alive   = (v.reset_at == 0) || (t <= v.reset_at);
         in_send = alive && (t <= NW);
         act_buf = '{m_buf, e_buf, n_buf, r_buf, t_buf};
         for (int i = 0; i < 5; i++) begin
            exp_buf[i] = in_send ? op[i][(t-1)*DW +: DW] : '0;
            chk($sformatf("%s buf%0d", tag, i), act_buf[i], exp_buf[i]);
         end
         chk({tag, " busy"}, 64'(busy), 64'(t <= last_busy));
         chk({tag, " start_input"}, 64'(start_input), 64'(in_send));
         chk({tag, " start_compute"}, 64'(start_compute), 64'(alive && t == S));
         chk({tag, " get_result"}, 64'(get_result), 64'(alive && t == S));
         chk({tag, " done"}, 64'(done), 64'(t == t_done));
         chk({tag, " timeout_err"}, 64'(timeout_err), 64'(t == t_to));
         chk({tag, " nprime0"}, nprime0, alive ? np : '0);
      end
      start = 1'b0;
      reset = 1'b0;
      if (v.exp_done)
         for (int k = 0; k < NW; k++) exp_res[k] = resw[k];
      if (v.reset_at != 0)
         for (int k = 0; k < NW; k++) exp_res[k] = '0;
      check_result(tag);
   endtask

   initial begin
      vecs[0] = '{mode:0, wait_cyc:5,  reset_at:0,  extra_start:0, exp_done:1, exp_timeout:0, exp_latency:2*NW+2+5};
      vecs[1] = '{mode:1, wait_cyc:1,  reset_at:0,  extra_start:0, exp_done:1, exp_timeout:0, exp_latency:2*NW+2+1};
      vecs[2] = '{mode:2, wait_cyc:0,  reset_at:0,  extra_start:1, exp_done:1, exp_timeout:0, exp_latency:0};
      vecs[3] = '{mode:2, wait_cyc:0,  reset_at:0,  extra_start:0, exp_done:0, exp_timeout:1, exp_latency:0};
      vecs[4] = '{mode:2, wait_cyc:TO-1, reset_at:0, extra_start:0, exp_done:1, exp_timeout:0, exp_latency:2*NW+2+TO-1};
      vecs[5] = '{mode:2, wait_cyc:7,  reset_at:21, extra_start:0, exp_done:0, exp_timeout:0, exp_latency:0};
      vecs[6] = '{mode:2, wait_cyc:TO-2, reset_at:0, extra_start:1, exp_done:1, exp_timeout:0, exp_latency:2*NW+2+TO-2};
      vecs[7] = '{mode:0, wait_cyc:3,  reset_at:0,  extra_start:0, exp_done:1, exp_timeout:0, exp_latency:2*NW+2+3};
      vecs[2].wait_cyc    = 2 + int'($urandom_range(0, 58));
      vecs[2].exp_latency = 2*NW + 2 + vecs[2].wait_cyc;

      reset     = 1'b1;
      start     = 1'b0;
      message   = '1;
      exponent  = '1;
      modulus   = '1;
      r_val     = '1;
      t_val     = '1;
      nprime_in = '1;
      exp_state = 5'd9;
      res_out   = '1;
      for (int k = 0; k < NW; k++) exp_res[k] = '0;

      // Reset state: every output low even with live-looking inputs and start
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset timeout_err", 64'(timeout_err), 64'd0);
      chk("reset start_input", 64'(start_input), 64'd0);
      chk("reset start_compute", 64'(start_compute), 64'd0);
      chk("reset get_result", 64'(get_result), 64'd0);
      chk("reset m_buf", m_buf, '0);
      chk("reset t_buf", t_buf, '0);
      chk("reset nprime0", nprime0, '0);
      check_result("reset");
      start     = 1'b0;
      reset     = 1'b0;
      exp_state = 5'd0;
      @(negedge clk);
      chk("idle busy", 64'(busy), 64'd0);

      for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
